// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the shared result bus and the ALU drive/return lines.
interface alu_arbiter_if #(
  parameter int unsigned W_IN  = 4,
  parameter int unsigned W_OUT = 8,
  parameter int unsigned W_OP  = 3
) ();
  logic             req0;
  logic [W_OP-1:0]  op0;
  logic [W_IN-1:0]  a0;
  logic [W_IN-1:0]  b0;
  logic             req1;
  logic [W_OP-1:0]  op1;
  logic [W_IN-1:0]  a1;
  logic [W_IN-1:0]  b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             err0;
  logic             err1;
  logic [W_OUT-1:0] res;
  logic             busy;
  logic [W_IN-1:0]  alu_in1;
  logic [W_IN-1:0]  alu_in2;
  logic [W_OP-1:0]  alu_s;
  logic             alu_ld;
  logic [W_OUT-1:0] alu_out;

  // Requester/ALU side of the bus.
  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    input  gnt0, gnt1, done0, done1, err0, err1, res, busy,
           alu_in1, alu_in2, alu_s, alu_ld
  );

  // Arbiter side of the bus.
  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    output gnt0, gnt1, done0, done1, err0, err1, res, busy,
           alu_in1, alu_in2, alu_s, alu_ld
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters.
// Each accepted op takes IDLE -> ISSUE (ALU load) -> CAPTURE (result to res, done pulse).
module alu_arbiter #(
  parameter int unsigned W_IN  = 4,
  parameter int unsigned W_OUT = 8,
  parameter int unsigned W_OP  = 3
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // Counting ops need several ALU cycles and are refused.
  localparam logic [W_OP-1:0] OP_UPCNT = W_OP'(5);
  localparam logic [W_OP-1:0] OP_DNCNT = W_OP'(6);

  state_e           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic             gnt0_q, gnt1_q;
  logic             done0_q, done1_q;
  logic             err0_q, err1_q;
  logic             busy_q;
  logic             ld_q;
  logic [W_OUT-1:0] res_q;
  logic [W_IN-1:0]  in1_q, in2_q;
  logic [W_OP-1:0]  s_q;

  logic             any_req;
  logic             sel_port;
  logic [W_OP-1:0]  sel_op;
  logic [W_IN-1:0]  sel_a, sel_b;
  logic             sel_reject;

  // Winner selection: on a tie the port not granted last time wins.
  always_comb begin
    any_req  = bus_io.req0 | bus_io.req1;
    sel_port = bus_io.req1;
    if (bus_io.req0 && bus_io.req1) begin
      sel_port = ~ptr_q;
    end
    sel_op     = sel_port ? bus_io.op1 : bus_io.op0;
    sel_a      = sel_port ? bus_io.a1  : bus_io.a0;
    sel_b      = sel_port ? bus_io.b1  : bus_io.b0;
    sel_reject = (sel_op == OP_UPCNT) || (sel_op == OP_DNCNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
      res_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      s_q     <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      ld_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt0_q <= ~sel_port;
            gnt1_q <= sel_port;
            ptr_q  <= sel_port;
            if (sel_reject) begin
              err0_q <= ~sel_port;
              err1_q <= sel_port;
            end else begin
              s_q     <= sel_op;
              in1_q   <= sel_a;
              in2_q   <= sel_b;
              owner_q <= sel_port;
              ld_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // ALU registered the result at the end of ISSUE.
          res_q   <= bus_io.alu_out;
          done0_q <= ~owner_q;
          done1_q <= owner_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_io.gnt0    = gnt0_q;
  assign bus_io.gnt1    = gnt1_q;
  assign bus_io.done0   = done0_q;
  assign bus_io.done1   = done1_q;
  assign bus_io.err0    = err0_q;
  assign bus_io.err1    = err1_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.res     = res_q;
  assign bus_io.alu_in1 = in1_q;
  assign bus_io.alu_in2 = in2_q;
  assign bus_io.alu_s   = s_q;
  assign bus_io.alu_ld  = ld_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then randomized two-port traffic.
module tb_alu_arbiter;

  logic clk;
  logic rst;

  alu_arbiter_if #(.W_IN(4), .W_OUT(8), .W_OP(3)) bus ();

  alu_arbiter #(.W_IN(4), .W_OUT(8), .W_OP(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         dly;
    int         exp;
  } item_t;

  typedef struct {
    int         port;
    logic [7:0] res;
    int         due;
  } exp_t;

  item_t      items[$];
  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         run    = 1'b0;
  int         cyc    = 0;
  int         mcyc   = 0;
  int         busy_cnt = 0;
  int         last   = 1;
  logic [1:0] req_v  = 2'b00;
  logic [2:0] op_v [2];
  logic [3:0] a_v  [2];
  logic [3:0] b_v  [2];
  logic [7:0] last_res = 8'd0;

  // Intended ALU behaviour, used both by the stand-in ALU and the expectations.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return 8'(a) + 8'(b);
      3'd1:    return 8'(a) - 8'(b);
      3'd2:    return 8'(a) + 8'd1;
      3'd3:    return 8'(a) - 8'd1;
      3'd4:    return (a > b) ? 8'd4 : ((a == b) ? 8'd1 : 8'd2);
      3'd7:    return {3'b000, a, 1'b0};
      default: return 8'd0;
    endcase
  endfunction

  // Registered ALU stand-in: result appears one edge after ld.
  always @(posedge clk) begin
    if (bus.alu_ld) bus.alu_out <= alu_f(bus.alu_s, bus.alu_in1, bus.alu_in2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"},  32'(bus.gnt0), 0);
    chk({tag, "_gnt1"},  32'(bus.gnt1), 0);
    chk({tag, "_done0"}, 32'(bus.done0), 0);
    chk({tag, "_done1"}, 32'(bus.done1), 0);
    chk({tag, "_err0"},  32'(bus.err0), 0);
    chk({tag, "_err1"},  32'(bus.err1), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_ld"},    32'(bus.alu_ld), 0);
    chk({tag, "_res"},   32'(bus.res), 0);
    chk({tag, "_in1"},   32'(bus.alu_in1), 0);
    chk({tag, "_in2"},   32'(bus.alu_in2), 0);
    chk({tag, "_s"},     32'(bus.alu_s), 0);
  endtask

  task automatic apply();
    bus.req0 = req_v[0]; bus.op0 = op_v[0]; bus.a0 = a_v[0]; bus.b0 = b_v[0];
    bus.req1 = req_v[1]; bus.op1 = op_v[1]; bus.a1 = a_v[1]; bus.b1 = b_v[1];
  endtask

  task automatic add(input int port, input int op, input int a, input int b, input int dly, input int expv);
    item_t it;
    it.port = port; it.op = 3'(op); it.a = 4'(a); it.b = 4'(b); it.dly = dly; it.exp = expv;
    items.push_back(it);
  endtask

  function automatic int head(input int p);
    foreach (items[i]) if (items[i].port == p) return i;
    return -1;
  endfunction

  // One sampled cycle: predict the arbiter's decision from the requests held
  // before the edge, compare, then advance each requester.
  task automatic driver_step();
    logic [1:0] g;
    bit         rej;
    bit         valid;
    int         win;
    int         h;
    exp_t       e;
    cyc++;
    g = 2'b00; rej = 1'b0; valid = 1'b0; win = 0;
    if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (req_v != 2'b00) begin
      win  = (req_v == 2'b11) ? ((last == 0) ? 1 : 0) : (req_v[1] ? 1 : 0);
      last = win;
      g[win] = 1'b1;
      rej  = (op_v[win] == 3'd5) || (op_v[win] == 3'd6);
      if (!rej) begin
        valid    = 1'b1;
        busy_cnt = 2;
        h = head(win);
        e.port = win;
        e.res  = (h >= 0 && items[h].exp >= 0) ? 8'(items[h].exp) : alu_f(op_v[win], a_v[win], b_v[win]);
        e.due  = cyc + 2;
        exp_q.push_back(e);
      end
    end
    chk("gnt0", 32'(bus.gnt0), 32'(g[0]));
    chk("gnt1", 32'(bus.gnt1), 32'(g[1]));
    chk("err0", 32'(bus.err0), 32'(rej && g[0]));
    chk("err1", 32'(bus.err1), 32'(rej && g[1]));
    chk("alu_ld", 32'(bus.alu_ld), 32'(valid));
    chk("busy", 32'(bus.busy), 32'(busy_cnt != 0));
    if (valid) begin
      chk("alu_s",   32'(bus.alu_s),   32'(op_v[win]));
      chk("alu_in1", 32'(bus.alu_in1), 32'(a_v[win]));
      chk("alu_in2", 32'(bus.alu_in2), 32'(b_v[win]));
    end
    if (g != 2'b00) begin
      h = head(win);
      if (h >= 0) items.delete(h);
      req_v[win] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!req_v[p]) begin
        h = head(p);
        if (h >= 0) begin
          if (items[h].dly > 0) begin
            items[h].dly--;
          end else begin
            req_v[p] = 1'b1;
            op_v[p]  = items[h].op;
            a_v[p]   = items[h].a;
            b_v[p]   = items[h].b;
          end
        end
      end
    end
    apply();
  endtask

  task automatic run_until_idle(input string phase);
    int k;
    k = 0;
    while (k < 5000 && !(items.size() == 0 && req_v == 2'b00 && busy_cnt == 0 && exp_q.size() == 0)) begin
      @(posedge clk); #1;
      driver_step();
      k++;
    end
    repeat (2) begin
      @(posedge clk); #1;
      driver_step();
    end
    n_chk++;
    if (k >= 5000) begin
      n_fail++;
      $display("FAIL %s_timeout: pending items %0d expected results %0d", phase, items.size(), exp_q.size());
      items.delete();
      req_v = 2'b00;
      apply();
    end
  endtask

  // Monitor: every done pops the oldest expected result; res must hold otherwise.
  always @(posedge clk) begin
    #1;
    if (run) begin
      exp_t e;
      mcyc++;
      if (bus.done0 || bus.done1) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'({bus.done1, bus.done0}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_port", 32'({bus.done1, bus.done0}), 32'(1) << e.port);
          chk("res", 32'(bus.res), 32'(e.res));
          chk("done_cycle", 32'(mcyc), 32'(e.due));
          last_res = e.res;
        end
      end else begin
        chk("res_hold", 32'(bus.res), 32'(last_res));
        if (exp_q.size() > 0 && exp_q[0].due < mcyc) begin
          e = exp_q.pop_front();
          chk("done_missing", 0, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin op_v[p] = '0; a_v[p] = '0; b_v[p] = '0; end
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Reset dropped in the middle of ISSUE: everything clears, no done follows.
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    req_v[0] = 1'b1; op_v[0] = 3'b000; a_v[0] = 4'b0010; b_v[0] = 4'b1010;
    apply();
    @(posedge clk); #1;
    chk("rstissue_gnt0", 32'(bus.gnt0), 1);
    chk("rstissue_ld",   32'(bus.alu_ld), 1);
    chk("rstissue_in1",  32'(bus.alu_in1), 2);
    chk("rstissue_in2",  32'(bus.alu_in2), 10);
    req_v[0] = 1'b0;
    apply();
    #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("postreset_done0", 32'(bus.done0), 0);
      chk("postreset_busy",  32'(bus.busy), 0);
      chk("postreset_ld",    32'(bus.alu_ld), 0);
    end
    run = 1'b1;

    // Tie right after reset: port 0, port 1, port 0.
    add(0, 1, 4'b1010, 4'b1001, 0, 1);
    add(0, 1, 4'b1010, 4'b1001, 0, 1);
    add(1, 7, 4'b1011, 4'b0110, 0, 22);
    run_until_idle("tie");

    add(0, 0, 4'b0010, 4'b1010, 0, 12);
    run_until_idle("add");

    add(1, 4, 4'b1001, 4'b0010, 0, 4);
    add(1, 4, 4'b0100, 4'b0100, 2, 1);
    run_until_idle("compare");

    add(0, 5, 4'b0011, 4'b0011, 0, -1);
    add(1, 6, 4'b0101, 4'b0001, 3, -1);
    run_until_idle("reject");

    // Port 1 raises its request while port 0 is in ISSUE.
    add(0, 0, 4'b0010, 4'b1010, 0, 12);
    add(1, 2, 4'b1111, 4'b0000, 1, 16);
    run_until_idle("late");

    for (int i = 0; i < 300; i++) begin
      add(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), -1);
    end
    run_until_idle("random");

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
